bank_buffer_reader: RTL and testbench
=====================================

# bank_buffer_reader

Read-side scheduler of the per-bank request buffers: each cycle it chooses one non-empty buffer, pops its head request, and presents it to the bank FSM on a valid/ready output stage. Row hits against the currently open row are preferred, with a streak cap for fairness. Sits between the bank's NUM_OF_BUFFERS show-ahead FIFOs, which are filled by the type selector, and the downstream command issue logic.

## Interface
- NUM_OF_BUFFERS, 4, number of request FIFOs drained
- BUFFER_SIZE, 4, depth of each FIFO (informational, unused in logic)
- REQUEST_SIZE, 32, request width before the type bit is stripped; stored entries are REQUEST_SIZE-1 bits
- ADDR_BITS, 8, width of the row field
- ADDR_FIRST_POS, 0, LSB position of the row field within a stored entry
- MAX_HITS, 4, maximum consecutive hit-preferred grants before a forced round-robin grant

- clk  in  1  clock; one clock domain; all state on rising edge
- reset  in  1  synchronous, active-high
- empty  in  NUM_OF_BUFFERS  per-FIFO empty flag
- head  in  NUM_OF_BUFFERS x (REQUEST_SIZE-1)  show-ahead head entry of each FIFO
- rd_en  out  NUM_OF_BUFFERS  one-hot pop strobe, combinational
- out_valid  out  1  output stage holds a request
- out_ready  in  1  downstream accepts the request
- out_data  out  REQUEST_SIZE-1  granted request
- out_row_hit  out  1  granted request matched the open row at grant time

## Operation
- slot_free = !out_valid || out_ready. A grant occurs when slot_free && !reset && |(~empty).
- Hit vector: hit[i] = !empty[i] && open_row_valid && head[i] row field == open_row.
- Grant choice:
  - If |hit and streak < MAX_HITS: hit grant. Lowest-index hit at or after rr_ptr (circular). rr_ptr unchanged; streak increments, saturating at MAX_HITS.
  - Otherwise: round-robin grant. First non-empty index at or after rr_ptr (circular). rr_ptr <= granted+1 mod NUM_OF_BUFFERS; streak <= 0.
- On grant: rd_en one-hot at the granted index; the next edge loads out_data <= head[g], out_valid <= 1, out_row_hit <= hit[g], open_row <= row field of head[g], open_row_valid <= 1.
- No grant while slot_free: the next edge clears out_valid. out_data holds its last value.
- Output FSM:
  - EMPTY: out_valid=0. Goes to FULL on a grant.
  - FULL: out_valid=1. Stays FULL if out_ready=0, or if out_ready=1 with a grant (back-to-back). Goes to EMPTY if out_ready=1 with no grant.
- Back-pressure: in FULL with out_ready=0, out_data and out_row_hit are stable and rd_en = 0.
- rd_en is never asserted for an empty FIFO and never asserted during reset.
- Reset mid-operation: a held request is discarded. The bank FIFOs are reset in the same cycle, so no request is lost relative to them.

## Timing
- Reset values: out_valid=0, out_data=0, out_row_hit=0, rd_en=0, open_row=0, open_row_valid=0, rr_ptr=0, streak=0, FSM=EMPTY.
- Latency: rd_en in cycle N, out_valid/out_data valid in cycle N+1.
- Throughput: one request per cycle while out_ready=1 and any FIFO is non-empty.
- Transfer occurs on any edge where out_valid && out_ready.
- The head inputs must reflect the post-pop head one cycle after rd_en (show-ahead FIFO contract).

## Structure
- Shared package bank_sched_pkg holds:
  - localparam widths ENTRY_W = REQUEST_SIZE-1 and ROW_W
  - typedef entry_t
  - a row_of(entry_t) function for row-field extraction, shared with the selector
  - the FSM enum {EMPTY, FULL}
- Sub-module rr_pick: combinational circular first-one finder with request vector, start pointer, one-hot grant and valid outputs. Instantiated twice, once for the hit vector and once for the non-empty vector.

## Test plan
- Reset: assert reset with all FIFOs non-empty -> rd_en=0 and out_valid=0 during reset; first grant on the cycle after deassertion is buffer 0.
- Round-robin: all four heads in distinct rows, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, out_row_hit=0 each time.
- Hit preference: open row 0x12 after the first grant; buffer 2 head row 0x12, buffers 1 and 3 rows 0x34 -> buffer 2 granted next with out_row_hit=1; rr_ptr unchanged.
- Streak cap: buffer 1 continuously supplies row 0x12, buffer 3 supplies row 0x55, MAX_HITS=4 -> four hit grants to buffer 1, then buffer 3 granted with out_row_hit=0.
- Back-pressure: hold out_ready=0 for 5 cycles with a request held -> out_data stable, rd_en=0 throughout; release -> accept and new grant on the same edge.
- Drain: single entry in buffer 3 only -> one grant, then with out_ready=1 out_valid drops next cycle; rd_en never hits an empty FIFO.

Source files
------------

// File: rtl/bank_sched_pkg.sv
// Shared types and widths for the bank request scheduler: stored entry format,
// row-field extraction and the output-stage state encoding.
package bank_sched_pkg;

  localparam int NUM_OF_BUFFERS = 4;
  localparam int BUFFER_SIZE    = 4;
  localparam int REQUEST_SIZE   = 32;
  localparam int ADDR_BITS      = 8;
  localparam int ADDR_FIRST_POS = 0;
  localparam int MAX_HITS       = 4;

  // Stored entries have already lost the request-type bit.
  localparam int ENTRY_W = REQUEST_SIZE - 1;
  localparam int ROW_W   = ADDR_BITS;

  typedef logic [ENTRY_W-1:0] entry_t;
  typedef logic [ROW_W-1:0]   row_t;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic row_t row_of(input entry_t e);
    return e[ADDR_FIRST_POS +: ROW_W];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-one finder: returns a one-hot grant for the first set request
// bit at or after the start pointer, wrapping around the vector.
module rr_pick
  import bank_sched_pkg::*;
#(
  parameter int N     = NUM_OF_BUFFERS,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] start,
  output logic [N-1:0]     grant,
  output logic             valid
);

  always_comb begin : pick
    int               sum;
    logic [PTR_W-1:0] idx;
    grant = '0;
    valid = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(start) + k;
      if (sum >= N) begin
        sum = sum - N;
      end else begin
        sum = sum;
      end
      idx = PTR_W'(sum);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/bank_buffer_reader.sv
// Read-side scheduler for the per-bank request FIFOs: pops one head per cycle,
// preferring open-row hits up to a streak cap, into a valid/ready output stage.
module bank_buffer_reader
  import bank_sched_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_OF_BUFFERS-1:0] empty,
  input  entry_t [NUM_OF_BUFFERS-1:0] head,
  output logic [NUM_OF_BUFFERS-1:0] rd_en,
  output logic                      out_valid,
  input  logic                      out_ready,
  output entry_t                    out_data,
  output logic                      out_row_hit
);

  localparam int PTR_W    = $clog2(NUM_OF_BUFFERS);
  localparam int STREAK_W = $clog2(MAX_HITS + 1);

  typedef logic [PTR_W-1:0]    ptr_t;
  typedef logic [STREAK_W-1:0] streak_t;

  out_state_e state_q, state_d;
  entry_t     out_data_q, out_data_d;
  logic       out_row_hit_q, out_row_hit_d;
  row_t       open_row_q, open_row_d;
  logic       open_row_valid_q, open_row_valid_d;
  ptr_t       rr_ptr_q, rr_ptr_d;
  streak_t    streak_q, streak_d;

  logic [NUM_OF_BUFFERS-1:0] hit_s;
  logic [NUM_OF_BUFFERS-1:0] nonempty_s;
  logic [NUM_OF_BUFFERS-1:0] hit_gnt_s;
  logic [NUM_OF_BUFFERS-1:0] ne_gnt_s;
  logic [NUM_OF_BUFFERS-1:0] gnt_vec_s;
  logic                      hit_any_s;
  logic                      ne_any_s;
  logic                      use_hit_s;
  logic                      slot_free_s;
  logic                      grant_s;
  ptr_t                      gnt_idx_s;

  always_comb begin
    hit_s      = '0;
    nonempty_s = ~empty;
    for (int i = 0; i < NUM_OF_BUFFERS; i++) begin
      hit_s[i] = !empty[i] && open_row_valid_q && (row_of(head[i]) == open_row_q);
    end
  end

  rr_pick #(.N(NUM_OF_BUFFERS), .PTR_W(PTR_W)) u_hit_pick (
    .req   (hit_s),
    .start (rr_ptr_q),
    .grant (hit_gnt_s),
    .valid (hit_any_s)
  );

  rr_pick #(.N(NUM_OF_BUFFERS), .PTR_W(PTR_W)) u_ne_pick (
    .req   (nonempty_s),
    .start (rr_ptr_q),
    .grant (ne_gnt_s),
    .valid (ne_any_s)
  );

  // Hit grants are only taken while the streak is below the cap, so the
  // round-robin pointer eventually serves every non-empty buffer.
  always_comb begin
    use_hit_s   = hit_any_s && (streak_q < STREAK_W'(MAX_HITS));
    slot_free_s = (state_q == EMPTY) || out_ready;
    grant_s     = slot_free_s && !reset && ne_any_s;
    gnt_vec_s   = use_hit_s ? hit_gnt_s : ne_gnt_s;
    rd_en       = grant_s ? gnt_vec_s : '0;
    gnt_idx_s   = '0;
    for (int i = 0; i < NUM_OF_BUFFERS; i++) begin
      if (gnt_vec_s[i]) begin
        gnt_idx_s = ptr_t'(i);
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  always_comb begin
    out_data_d       = out_data_q;
    out_row_hit_d    = out_row_hit_q;
    open_row_d       = open_row_q;
    open_row_valid_d = open_row_valid_q;
    rr_ptr_d         = rr_ptr_q;
    streak_d         = streak_q;
    if (grant_s) begin
      out_data_d       = head[gnt_idx_s];
      out_row_hit_d    = hit_s[gnt_idx_s];
      open_row_d       = row_of(head[gnt_idx_s]);
      open_row_valid_d = 1'b1;
      if (use_hit_s) begin
        if (streak_q == STREAK_W'(MAX_HITS)) begin
          streak_d = streak_q;
        end else begin
          streak_d = streak_q + STREAK_W'(1);
        end
      end else begin
        streak_d = '0;
        if (gnt_idx_s == ptr_t'(NUM_OF_BUFFERS - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = gnt_idx_s + ptr_t'(1);
        end
      end
    end else begin
      out_data_d = out_data_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (grant_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (!out_ready || grant_s) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    out_valid   = (state_q == FULL);
    out_data    = out_data_q;
    out_row_hit = out_row_hit_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= EMPTY;
      out_data_q       <= '0;
      out_row_hit_q    <= 1'b0;
      open_row_q       <= '0;
      open_row_valid_q <= 1'b0;
      rr_ptr_q         <= '0;
      streak_q         <= '0;
    end else begin
      state_q          <= state_d;
      out_data_q       <= out_data_d;
      out_row_hit_q    <= out_row_hit_d;
      open_row_q       <= open_row_d;
      open_row_valid_q <= open_row_valid_d;
      rr_ptr_q         <= rr_ptr_d;
      streak_q         <= streak_d;
    end
  end

endmodule

// File: tb/tb_bank_buffer_reader.sv
// Self-checking bench for bank_buffer_reader: per-cycle expectation tables plus
// a scoreboard of granted entries drawn from the bench's own FIFO model.
module tb_bank_buffer_reader;
  import bank_sched_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       empty;
  logic [3:0][30:0] head;
  logic [3:0]       rd_en;
  logic             out_valid;
  logic             out_ready;
  logic [30:0]      out_data;
  logic             out_row_hit;

  always #5 clk = ~clk;

  bank_buffer_reader dut (
    .clk         (clk),
    .reset       (reset),
    .empty       (empty),
    .head        (head),
    .rd_en       (rd_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_row_hit (out_row_hit)
  );

  typedef struct packed {
    logic [30:0] data;
    logic        hit;
  } exp_t;

  typedef struct packed {
    logic       rdy;
    logic [3:0] rd;
    logic       hit;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [30:0] fmem [4][8];
  int          fcnt [4];
  exp_t        sb [$];
  logic        exp_valid;
  vec_t        tbl [12];
  int          ntbl = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      empty[i] = (fcnt[i] == 0);
      head[i]  = (fcnt[i] != 0) ? fmem[i][0] : 31'd0;
    end
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 4; i++) fcnt[i] = 0;
  endtask

  task automatic push_entry(input int b, input logic [7:0] tag, input logic [7:0] row);
    fmem[b][fcnt[b]] = {15'd0, tag, row};
    fcnt[b]++;
  endtask

  task automatic pop_entry(input int b);
    for (int k = 0; k < 7; k++) fmem[b][k] = fmem[b][k+1];
    fcnt[b]--;
  endtask

  task automatic add(input logic rdy, input logic [3:0] rd, input logic hit);
    tbl[ntbl] = '{rdy: rdy, rd: rd, hit: hit};
    ntbl++;
  endtask

  // One clock: entered and left at a falling edge.
  task automatic cycle(input string name, input logic rdy, input logic [3:0] exp_rd,
                       input logic exp_hit);
    int   g;
    exp_t front;
    g = -1;
    out_ready = rdy;
    #1;
    check({name, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    if (exp_valid) begin
      if (sb.size() == 0) begin
        check({name, ".sb_nonempty"}, 32'd0, 32'd1);
      end else begin
        front = sb[0];
        check({name, ".out_data"}, 32'(out_data), 32'(front.data));
        check({name, ".out_row_hit"}, 32'(out_row_hit), 32'(front.hit));
      end
    end
    check({name, ".rd_en"}, 32'(rd_en), 32'(exp_rd));
    check({name, ".rd_en_on_empty"}, 32'(rd_en & empty), 32'd0);
    for (int i = 0; i < 4; i++) if (exp_rd[i]) g = i;
    if (g >= 0) sb.push_back('{data: fmem[g][0], hit: exp_hit});
    @(posedge clk);
    if (exp_valid && rdy && sb.size() != 0) void'(sb.pop_front());
    if (g >= 0) pop_entry(g);
    exp_valid = (g >= 0) || (exp_valid && !rdy);
    #1;
    drive_inputs();
    @(negedge clk);
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < ntbl; i++) begin
      cycle($sformatf("%s[%0d]", name, i), tbl[i].rdy, tbl[i].rd, tbl[i].hit);
    end
    ntbl = 0;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst.rd_en_first", 32'(rd_en), 32'd0);
    @(posedge clk);
    #1;
    sb.delete();
    exp_valid = 1'b0;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data", 32'(out_data), 32'd0);
    check("rst.out_row_hit", 32'(out_row_hit), 32'd0);
    @(negedge clk);
    check("rst.rd_en_held", 32'(rd_en), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    exp_valid = 1'b0;
    clear_fifos();
    drive_inputs();
    @(negedge clk);

    // Round-robin over four distinct rows, then drain.
    clear_fifos();
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 2; k++) push_entry(b, 8'(b * 16 + k), 8'(8'h40 + 16 * k + b));
    drive_inputs();
    apply_reset();
    add(1'b1, 4'b0001, 1'b0); add(1'b1, 4'b0010, 1'b0); add(1'b1, 4'b0100, 1'b0);
    add(1'b1, 4'b1000, 1'b0); add(1'b1, 4'b0001, 1'b0); add(1'b1, 4'b0010, 1'b0);
    add(1'b1, 4'b0100, 1'b0); add(1'b1, 4'b1000, 1'b0); add(1'b1, 4'b0000, 1'b0);
    add(1'b1, 4'b0000, 1'b0);
    run_table("rr");

    // Hit preference leaves the round-robin pointer where it was.
    clear_fifos();
    push_entry(0, 8'h01, 8'h12); push_entry(1, 8'h11, 8'h34);
    push_entry(2, 8'h21, 8'h12); push_entry(3, 8'h31, 8'h34);
    drive_inputs();
    apply_reset();
    add(1'b1, 4'b0001, 1'b0); add(1'b1, 4'b0100, 1'b1); add(1'b1, 4'b0010, 1'b0);
    add(1'b1, 4'b1000, 1'b1); add(1'b1, 4'b0000, 1'b0); add(1'b1, 4'b0000, 1'b0);
    run_table("hit");

    // Streak cap: four hits to buffer 1, then a forced grant to buffer 3.
    clear_fifos();
    for (int k = 0; k < 6; k++) push_entry(1, 8'(8'h10 + k), 8'h12);
    for (int k = 0; k < 2; k++) push_entry(3, 8'(8'h30 + k), 8'h55);
    drive_inputs();
    apply_reset();
    add(1'b1, 4'b0010, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b1, 4'b0010, 1'b1);
    add(1'b1, 4'b1000, 1'b0); add(1'b1, 4'b1000, 1'b1); add(1'b1, 4'b0010, 1'b0);
    add(1'b1, 4'b0000, 1'b0); add(1'b1, 4'b0000, 1'b0);
    run_table("streak");

    // Back-pressure for five cycles, release, then hold again before a reset.
    clear_fifos();
    for (int k = 0; k < 4; k++) push_entry(0, 8'(8'h50 + k), 8'(k + 1));
    drive_inputs();
    apply_reset();
    add(1'b1, 4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b0, 4'b0000, 1'b0);
    add(1'b1, 4'b0001, 1'b0); add(1'b1, 4'b0001, 1'b0); add(1'b0, 4'b0000, 1'b0);
    run_table("bp");

    // Single entry in buffer 3; reset also discards the request held above.
    clear_fifos();
    push_entry(3, 8'h70, 8'h77);
    drive_inputs();
    apply_reset();
    add(1'b1, 4'b1000, 1'b0); add(1'b1, 4'b0000, 1'b0); add(1'b1, 4'b0000, 1'b0);
    run_table("drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
